oqpsk_burst_scheduler: RTL and testbench
========================================

Name: oqpsk_burst_scheduler

Overview:
Sequences the I/Q bit-extraction register stage of the OQPSK transmitter. Accepts 64-bit AXI-Stream beats and issues the per-rail load strobes (start_fsms, inphase_receive_data, quadrature_receive_data). Tracks the symbol, sample and packet positions on each rail, with the quadrature rail lagging the inphase rail by half a symbol. Completes each AXIS handshake only after both rails have captured their half of the beat.

Parameters:
SAMPLES_PER_SYMBOL, 4, samples per symbol per rail; even, >=2
C_S00_AXIS_TDATA_WIDTH, 64, beat width; each rail takes W/2 bits per beat
BURST_SIZE, 2, beats (packets) per burst; >=2

Ports:
aclk  in  1  clock; all logic on rising edge
sresetn  in  1  synchronous active-low reset
s00_axis_tvalid  in  1  upstream beat valid; held until handshake (AXIS rule)
s00_axis_tready  out  1  beat consumed when tvalid&&tready
sample_enable  in  1  downstream sample strobe; all rail counters advance only when high
start_fsms  out  1  one-cycle pulse: load both rails from current beat
inphase_receive_data  out  1  one-cycle pulse: load I half of current beat
quadrature_receive_data  out  1  one-cycle pulse: load Q half of current beat
inphase_packet_counter  out  $clog2(BURST_SIZE)  index of packet on I rail
quadrature_packet_counter  out  $clog2(BURST_SIZE)  index of packet on Q rail
last_inphase_sample_of_packet  out  1  high on the final I sample of a packet
last_quadrature_sample_of_packet  out  1  high on the final Q sample of a packet
inphase_bit_index  out  $clog2(W/2)  current I symbol within packet
quadrature_bit_index  out  $clog2(W/2)  current Q symbol within packet
inphase_active  out  1  I rail emitting samples
quadrature_active  out  1  Q rail emitting samples
underrun  out  1  one-cycle pulse: beat absent at an I packet boundary mid-burst
busy  out  1  state != IDLE

Behaviour:
- Reset (sresetn=0 at posedge): state IDLE; all outputs and counters 0; tready=0. Applies mid-burst; no partial flush.
- Constants: N = (W/2)*SPS samples per packet per rail; H = SPS/2.
- States: IDLE, RUN, DRAIN_Q.
- IDLE: when tvalid=1, assert start_fsms=1 and tready=1 in the same cycle, independent of sample_enable.
  - Beat 0 is consumed.
  - Clear I/Q sample, bit and packet counters; go to RUN.
- I rail sample k = k-th sample_enable cycle after the start cycle, k from 0.
  - Per-rail sample index s (0..SPS-1) and bit index b (0..W/2-1) advance on each enabled sample; bit = position/SPS.
- inphase_active=1 from sample 0. quadrature_active=1 from I sample H; Q counters hold at 0 until then (half-symbol offset).
- last_*_sample_of_packet: combinational, high when that rail is active, sample_enable=1, s=SPS-1 and b=W/2-1.
- I boundary (last_inphase high):
  - If the I packet counter is not BURST_SIZE-1 and tvalid=1: pulse inphase_receive_data and increment the I packet counter. Do NOT assert tready.
  - If the counter is BURST_SIZE-1: burst end. No load; I counter wraps to 0; inphase_active=0; go to DRAIN_Q.
  - If tvalid=0 mid-burst: pulse underrun. No load; inphase_active=0; go to DRAIN_Q.
- Q boundary (last_quadrature high), H samples after the matching I boundary:
  - If that I boundary loaded: pulse quadrature_receive_data with tready=1 (pop the beat); increment the Q packet counter (wraps at BURST_SIZE).
  - In DRAIN_Q: no load, no tready; quadrature_active=0; go to IDLE next cycle. A new start is accepted the cycle after.
- tready is high only in the IDLE start cycle and in Q-load cycles. Strobes never assert without sample_enable, except start_fsms.
- Simultaneous events: start_fsms and the receive pulses are mutually exclusive by construction. The I and Q boundaries never coincide (H>=1).
- sample_enable low: all counters, flags and pulses are frozen or suppressed. The state is held.

Test Plan:
- Reset: hold sresetn=0 for 3 cycles with tvalid=1 -> all outputs 0, tready=0, busy=0.
- Normal start (SPS=4, W=64, N=128, enable=1, two beats available):
  - Cycle 0: start_fsms=1, tready=1.
  - I sample 127: last_inphase=1, inphase_receive_data=1, tready=0; inphase_packet_counter becomes 1.
  - I sample 129: last_quadrature=1, quadrature_receive_data=1, tready=1.
- Burst end (BURST_SIZE=2):
  - I sample 255: last_inphase=1, no load, inphase_active falls.
  - Sample 257: last_quadrature=1, no tready; busy=0 next cycle; new start accepted the cycle after.
- Underrun: tvalid=0 at I sample 127 -> underrun=1 one cycle; no receive pulses; Q finishes at 129; then IDLE.
- Sample gaps: sample_enable alternates 1/0 -> first I boundary at enabled sample 127 (cycle ~254); no strobe in any disabled cycle; counters held.
- Reset mid-run at I sample 60 -> all outputs 0 next cycle; subsequent tvalid gives a clean start_fsms with counters at 0.

Source files
------------

// File: rtl/oqpsk_burst_scheduler.sv
// oqpsk_burst_scheduler
//   Sequences the I/Q bit-extraction register stage of an OQPSK transmitter.
//   A burst starts when an AXIS beat arrives in IDLE: that beat loads both rails.
//   The I rail then walks every sample of every symbol of the packet. The Q rail
//   walks the same positions half a symbol later. At each I packet boundary the
//   I half of the next beat is loaded. The matching Q boundary loads the Q half
//   and completes the AXIS handshake.
// Ports
//   aclk, sresetn                       clock, synchronous active-low reset
//   s00_axis_tvalid / s00_axis_tready   upstream beat handshake
//   sample_enable                       downstream sample strobe (gates all rail motion)
//   start_fsms                          pulse: load both rails from the current beat
//   inphase/quadrature_receive_data     pulse: load I / Q half of the current beat
//   *_packet_counter, *_bit_index       packet and symbol position on each rail
//   last_*_sample_of_packet             final sample of a packet on that rail
//   inphase_active, quadrature_active   rail is emitting samples
//   underrun                            pulse: no beat available at a mid-burst I boundary
//   busy                                scheduler not idle
module oqpsk_burst_scheduler #(
    parameter int unsigned SAMPLES_PER_SYMBOL     = 4,
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 64,
    parameter int unsigned BURST_SIZE             = 2
) (
    input  logic                                      aclk,
    input  logic                                      sresetn,
    input  logic                                      s00_axis_tvalid,
    output logic                                      s00_axis_tready,
    input  logic                                      sample_enable,
    output logic                                      start_fsms,
    output logic                                      inphase_receive_data,
    output logic                                      quadrature_receive_data,
    output logic [$clog2(BURST_SIZE)-1:0]             inphase_packet_counter,
    output logic [$clog2(BURST_SIZE)-1:0]             quadrature_packet_counter,
    output logic                                      last_inphase_sample_of_packet,
    output logic                                      last_quadrature_sample_of_packet,
    output logic [$clog2(C_S00_AXIS_TDATA_WIDTH/2)-1:0] inphase_bit_index,
    output logic [$clog2(C_S00_AXIS_TDATA_WIDTH/2)-1:0] quadrature_bit_index,
    output logic                                      inphase_active,
    output logic                                      quadrature_active,
    output logic                                      underrun,
    output logic                                      busy
);

    localparam int unsigned BITS = C_S00_AXIS_TDATA_WIDTH / 2;
    localparam int unsigned SW   = $clog2(SAMPLES_PER_SYMBOL);
    localparam int unsigned BW   = $clog2(BITS);
    localparam int unsigned PW   = $clog2(BURST_SIZE);
    localparam int unsigned H    = SAMPLES_PER_SYMBOL / 2;

    localparam logic [SW-1:0] S_LAST   = SW'(SAMPLES_PER_SYMBOL - 1);
    localparam logic [SW-1:0] S_QSTART = SW'(H - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(BITS - 1);
    localparam logic [PW-1:0] P_LAST   = PW'(BURST_SIZE - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrainQ} state_t;

    state_t         r_state, w_state_nx;
    logic [SW-1:0]  r_i_sample, w_i_sample_nx, r_q_sample, w_q_sample_nx;
    logic [BW-1:0]  r_i_bit, w_i_bit_nx, r_q_bit, w_q_bit_nx;
    logic [PW-1:0]  r_i_pkt, w_i_pkt_nx, r_q_pkt, w_q_pkt_nx;
    logic           r_i_active, w_i_active_nx, r_q_active, w_q_active_nx;
    logic           w_start, w_tready, w_rx_i, w_rx_q, w_underrun, w_last_i, w_last_q;

    always_ff @(posedge aclk) begin
        if (!sresetn) begin
            r_state    <= StIdle;
            r_i_sample <= '0;
            r_q_sample <= '0;
            r_i_bit    <= '0;
            r_q_bit    <= '0;
            r_i_pkt    <= '0;
            r_q_pkt    <= '0;
            r_i_active <= 1'b0;
            r_q_active <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_i_sample <= w_i_sample_nx;
            r_q_sample <= w_q_sample_nx;
            r_i_bit    <= w_i_bit_nx;
            r_q_bit    <= w_q_bit_nx;
            r_i_pkt    <= w_i_pkt_nx;
            r_q_pkt    <= w_q_pkt_nx;
            r_i_active <= w_i_active_nx;
            r_q_active <= w_q_active_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_i_sample_nx = r_i_sample;
        w_q_sample_nx = r_q_sample;
        w_i_bit_nx    = r_i_bit;
        w_q_bit_nx    = r_q_bit;
        w_i_pkt_nx    = r_i_pkt;
        w_q_pkt_nx    = r_q_pkt;
        w_i_active_nx = r_i_active;
        w_q_active_nx = r_q_active;
        w_start       = 1'b0;
        w_tready      = 1'b0;
        w_rx_i        = 1'b0;
        w_rx_q        = 1'b0;
        w_underrun    = 1'b0;
        w_last_i = r_i_active && sample_enable && (r_i_sample == S_LAST) && (r_i_bit == B_LAST);
        w_last_q = r_q_active && sample_enable && (r_q_sample == S_LAST) && (r_q_bit == B_LAST);

        case (r_state)
            StIdle: begin
                if (s00_axis_tvalid) begin
                    w_start       = 1'b1;
                    w_tready      = 1'b1;
                    w_i_sample_nx = '0;
                    w_q_sample_nx = '0;
                    w_i_bit_nx    = '0;
                    w_q_bit_nx    = '0;
                    w_i_pkt_nx    = '0;
                    w_q_pkt_nx    = '0;
                    w_i_active_nx = 1'b1;
                    w_q_active_nx = 1'b0;
                    w_state_nx    = StRun;
                end
            end
            StRun, StDrainQ: begin
                // I rail
                if (r_i_active && sample_enable) begin
                    if (w_last_i) begin
                        w_i_sample_nx = '0;
                        w_i_bit_nx    = '0;
                        if ((r_i_pkt != P_LAST) && s00_axis_tvalid) begin
                            w_rx_i     = 1'b1;
                            w_i_pkt_nx = r_i_pkt + PW'(1);
                        end else begin
                            if (r_i_pkt == P_LAST) begin
                                w_i_pkt_nx = '0;
                            end else begin
                                w_underrun = 1'b1;
                            end
                            w_i_active_nx = 1'b0;
                            w_state_nx    = StDrainQ;
                        end
                    end else if (r_i_sample == S_LAST) begin
                        w_i_sample_nx = '0;
                        w_i_bit_nx    = r_i_bit + BW'(1);
                    end else begin
                        w_i_sample_nx = r_i_sample + SW'(1);
                    end
                end
                // Q rail wakes up so that its sample 0 coincides with I sample H
                if (!r_q_active && r_i_active && sample_enable && (r_i_pkt == '0) &&
                    (r_i_bit == '0) && (r_i_sample == S_QSTART)) begin
                    w_q_active_nx = 1'b1;
                end
                // Q rail: every Q boundary seen in RUN follows an I boundary that loaded
                if (r_q_active && sample_enable) begin
                    if (w_last_q) begin
                        w_q_sample_nx = '0;
                        w_q_bit_nx    = '0;
                        if (r_state == StRun) begin
                            w_rx_q     = 1'b1;
                            w_tready   = 1'b1;
                            w_q_pkt_nx = (r_q_pkt == P_LAST) ? '0 : r_q_pkt + PW'(1);
                        end else begin
                            w_q_active_nx = 1'b0;
                            w_state_nx    = StIdle;
                        end
                    end else if (r_q_sample == S_LAST) begin
                        w_q_sample_nx = '0;
                        w_q_bit_nx    = r_q_bit + BW'(1);
                    end else begin
                        w_q_sample_nx = r_q_sample + SW'(1);
                    end
                end
            end
            default: w_state_nx = StIdle;
        endcase
    end

    // Combinational strobes are masked while reset is asserted
    assign start_fsms                       = w_start && sresetn;
    assign s00_axis_tready                  = w_tready && sresetn;
    assign inphase_receive_data             = w_rx_i && sresetn;
    assign quadrature_receive_data          = w_rx_q && sresetn;
    assign underrun                         = w_underrun && sresetn;
    assign last_inphase_sample_of_packet    = w_last_i && sresetn;
    assign last_quadrature_sample_of_packet = w_last_q && sresetn;
    assign inphase_packet_counter           = r_i_pkt;
    assign quadrature_packet_counter        = r_q_pkt;
    assign inphase_bit_index                = r_i_bit;
    assign quadrature_bit_index             = r_q_bit;
    assign inphase_active                   = r_i_active;
    assign quadrature_active                = r_q_active;
    assign busy                             = (r_state != StIdle);

endmodule

// File: tb/tb_oqpsk_burst_scheduler.sv
// tb_oqpsk_burst_scheduler
//   Randomized bench for oqpsk_burst_scheduler. The reference model counts
//   enabled samples since the start of a burst and derives rail positions,
//   boundaries and strobes with plain arithmetic on that count.
module tb_oqpsk_burst_scheduler;

    localparam int SPS = 4;
    localparam int W   = 64;
    localparam int B   = 2;
    localparam int NB  = W / 2;
    localparam int N   = NB * SPS;
    localparam int H   = SPS / 2;

    logic       aclk = 1'b0;
    logic       sresetn, tvalid, tready, en;
    logic       start, rx_i, rx_q, last_i, last_q, i_act, q_act, und, busy;
    logic [0:0] i_pkt, q_pkt;
    logic [4:0] i_bit, q_bit;

    always #5 aclk = ~aclk;

    oqpsk_burst_scheduler #(
        .SAMPLES_PER_SYMBOL     (SPS),
        .C_S00_AXIS_TDATA_WIDTH (W),
        .BURST_SIZE             (B)
    ) dut (
        .aclk                             (aclk),
        .sresetn                          (sresetn),
        .s00_axis_tvalid                  (tvalid),
        .s00_axis_tready                  (tready),
        .sample_enable                    (en),
        .start_fsms                       (start),
        .inphase_receive_data             (rx_i),
        .quadrature_receive_data          (rx_q),
        .inphase_packet_counter           (i_pkt),
        .quadrature_packet_counter        (q_pkt),
        .last_inphase_sample_of_packet    (last_i),
        .last_quadrature_sample_of_packet (last_q),
        .inphase_bit_index                (i_bit),
        .quadrature_bit_index             (q_bit),
        .inphase_active                   (i_act),
        .quadrature_active                (q_act),
        .underrun                         (und),
        .busy                             (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        n_checks++;
        if (obs !== 32'(exp)) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s observed=%0d expected=%0d time=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 bursting, 2 draining Q
    int m_mode = 0;
    int m_k    = 0;   // enabled samples completed since the start cycle
    int m_ipkt = 0;
    int m_qpkt = 0;
    bit pend_drop = 1'b0;

    task automatic cycle(input bit rst_v, input bit en_v, input int raise_pct, input bit do_chk);
        bit e_start, e_iact, e_qact, e_last_i, e_last_q, e_rxi, e_rxq, e_und, e_tready;
        int e_ibit, e_qbit;
        @(negedge aclk);
        if (pend_drop) tvalid = 1'b0;
        pend_drop = 1'b0;
        sresetn = rst_v;
        en      = en_v;
        if (!tvalid && ($urandom_range(99) < raise_pct)) tvalid = 1'b1;
        #1;
        e_start  = rst_v && (m_mode == 0) && tvalid;
        e_iact   = (m_mode == 1);
        e_qact   = (m_mode != 0) && (m_k >= H);
        e_last_i = rst_v && en_v && e_iact && ((m_k % N) == N - 1);
        e_last_q = rst_v && en_v && e_qact && (((m_k - H) % N) == N - 1);
        e_rxi    = e_last_i && (m_ipkt != B - 1) && tvalid;
        e_und    = e_last_i && (m_ipkt != B - 1) && !tvalid;
        e_rxq    = e_last_q && (m_mode == 1);
        e_tready = e_start || e_rxq;
        e_ibit   = e_iact ? (m_k % N) / SPS : 0;
        e_qbit   = e_qact ? ((m_k - H) % N) / SPS : 0;
        if (do_chk) begin
            check("start_fsms", 32'(start), int'(e_start));
            check("tready", 32'(tready), int'(e_tready));
            check("rx_i", 32'(rx_i), int'(e_rxi));
            check("rx_q", 32'(rx_q), int'(e_rxq));
            check("underrun", 32'(und), int'(e_und));
            check("last_i", 32'(last_i), int'(e_last_i));
            check("last_q", 32'(last_q), int'(e_last_q));
            check("i_active", 32'(i_act), int'(e_iact));
            check("q_active", 32'(q_act), int'(e_qact));
            check("busy", 32'(busy), int'(m_mode != 0));
            check("i_bit", 32'(i_bit), e_ibit);
            check("q_bit", 32'(q_bit), e_qbit);
            check("i_pkt", 32'(i_pkt), m_ipkt);
            check("q_pkt", 32'(q_pkt), m_qpkt);
        end
        // Advance model to the state after this clock edge
        if (!rst_v) begin
            m_mode = 0;
            m_k    = 0;
            m_ipkt = 0;
            m_qpkt = 0;
        end else if (e_start) begin
            m_mode = 1;
            m_k    = 0;
            m_ipkt = 0;
            m_qpkt = 0;
        end else if (m_mode != 0 && en_v) begin
            if (e_last_i) begin
                if (e_rxi) begin
                    m_ipkt++;
                end else begin
                    if (m_ipkt == B - 1) m_ipkt = 0;
                    m_mode = 2;
                end
            end
            if (e_last_q) begin
                if (e_rxq) m_qpkt = (m_qpkt + 1) % B;
                else       m_mode = 0;
            end
            m_k++;
        end
        pend_drop = rst_v && tvalid && e_tready;
    endtask

    initial begin
        sresetn = 1'b0;
        en      = 1'b0;
        tvalid  = 1'b1;
        // Three reset cycles with tvalid high; the first edge initialises the DUT
        cycle(1'b0, 1'b1, 0, 1'b0);
        cycle(1'b0, 1'b1, 0, 1'b1);
        cycle(1'b0, 1'b1, 0, 1'b1);
        // Continuous enable, beats readily available
        for (int i = 0; i < 800; i++) cycle(1'b1, 1'b1, 90, 1'b1);
        // Alternating enable
        for (int i = 0; i < 1400; i++) cycle(1'b1, (i % 2) == 0, 90, 1'b1);
        // Sparse beats: underruns at mid-burst boundaries
        for (int i = 0; i < 2000; i++) cycle(1'b1, 1'b1, 1, 1'b1);
        // Mixed: random enable, random beat rate, occasional reset mid-run
        for (int i = 0; i < 5000; i++) begin
            cycle($urandom_range(399) != 0, $urandom_range(99) < 75,
                  ((i / 600) % 2) == 0 ? 60 : 1, 1'b1);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
